// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of the hazard controller's datapath-facing signals.
// The master is the datapath side; the slave is pipeline_hazard_ctrl.
interface pipeline_hazard_ctrl_if;
    logic [4:0]  id_rn;
    logic [4:0]  id_rm;
    logic        id_uses_rn;
    logic        id_uses_rm;
    logic        ex_memread;
    logic [4:0]  ex_rd;
    logic        ex_multicycle;
    logic        br_taken;
    logic        imem_ready;
    logic        pc_we;
    logic        ifid_we;
    logic        ifid_flush;
    logic        idex_we;
    logic        idex_bubble;
    logic        exmem_bubble;
    logic [31:0] stall_cycles;
    logic [31:0] flush_cycles;

    modport master (
        output id_rn, id_rm, id_uses_rn, id_uses_rm, ex_memread, ex_rd,
               ex_multicycle, br_taken, imem_ready,
        input  pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_bubble,
               stall_cycles, flush_cycles
    );

    modport slave (
        input  id_rn, id_rm, id_uses_rn, id_uses_rm, ex_memread, ex_rd,
               ex_multicycle, br_taken, imem_ready,
        output pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_bubble,
               stall_cycles, flush_cycles
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/bubble controller for the 5-stage pipeline (load-use, branch, fetch wait, multicycle EX).
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int MC_LAT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    pipeline_hazard_ctrl_if.slave hz
);
    typedef enum logic [0:0] {RUN, MC_STALL} state_t;

    // The first stall cycle happens in RUN, so the down-counter covers the rest minus release.
    localparam logic [3:0] MC_INIT = 4'(MC_LAT - 2);

    state_t     state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;
    logic       lu_hazard;
    logic       pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_bubble;

    assign lu_hazard = hz.ex_memread && (hz.ex_rd != 5'd31) &&
                       ((hz.id_uses_rn && (hz.id_rn == hz.ex_rd)) ||
                        (hz.id_uses_rm && (hz.id_rm == hz.ex_rd)));

    always_comb begin
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        idex_we      = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        if (reset) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idex_we      = 1'b0;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            exmem_bubble = 1'b1;
        end else begin
            case (state_reg)
                RUN: begin
                    if (hz.br_taken) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (hz.ex_multicycle) begin
                        pc_we        = 1'b0;
                        ifid_we      = 1'b0;
                        idex_we      = 1'b0;
                        exmem_bubble = 1'b1;
                        state_next   = MC_STALL;
                        cnt_next     = MC_INIT;
                    end else if (lu_hazard) begin
                        pc_we       = 1'b0;
                        ifid_we     = 1'b0;
                        idex_bubble = 1'b1;
                    end else if (!hz.imem_ready) begin
                        pc_we      = 1'b0;
                        ifid_flush = 1'b1;
                    end
                end
                MC_STALL: begin
                    // Branch, load-use and fetch state are frozen behind the held IF/ID.
                    if (cnt_reg != 4'd0) begin
                        pc_we        = 1'b0;
                        ifid_we      = 1'b0;
                        idex_we      = 1'b0;
                        exmem_bubble = 1'b1;
                        cnt_next     = cnt_reg - 4'd1;
                    end else begin
                        state_next = RUN;
                    end
                end
                default: state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= RUN;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign hz.pc_we        = pc_we;
    assign hz.ifid_we      = ifid_we;
    assign hz.ifid_flush   = ifid_flush;
    assign hz.idex_we      = idex_we;
    assign hz.idex_bubble  = idex_bubble;
    assign hz.exmem_bubble = exmem_bubble;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_reg, flush_cycles_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_reg <= 32'd0;
            flush_cycles_reg <= 32'd0;
        end else begin
            if (!pc_we)
                stall_cycles_reg <= stall_cycles_reg + 32'd1;
            if (ifid_flush)
                flush_cycles_reg <= flush_cycles_reg + 32'd1;
        end
    end

    assign hz.stall_cycles = stall_cycles_reg;
    assign hz.flush_cycles = flush_cycles_reg;
`else
    assign hz.stall_cycles = 32'd0;
    assign hz.flush_cycles = 32'd0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: expected control vectors are queued when a step
// is driven and compared at the falling edge; perf counters are checked against a running tally.
module tb_pipeline_hazard_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if hz ();

    pipeline_hazard_ctrl #(.MC_LAT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz.slave)
    );

    // {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_bubble}
    localparam logic [5:0] V_DEF = 6'b110100;
    localparam logic [5:0] V_RST = 6'b001011;
    localparam logic [5:0] V_LU  = 6'b000110;
    localparam logic [5:0] V_BR  = 6'b111110;
    localparam logic [5:0] V_MC  = 6'b000001;
    localparam logic [5:0] V_FW  = 6'b011100;

    typedef struct {
        logic [5:0] v;
        logic       rst;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int errors = 0;
    int checks = 0;
    logic [31:0] stall_model = 32'd0;
    logic [31:0] flush_model = 32'd0;

    task automatic step(input logic rst, input logic [4:0] rn, input logic [4:0] rm,
                        input logic urn, input logic urm, input logic memread,
                        input logic [4:0] rd, input logic mc, input logic br,
                        input logic rdy, input logic [5:0] expv, input string tag);
        exp_t e;
        logic [5:0] obs;
        logic [31:0] exp_stall, exp_flush;
        reset            = rst;
        hz.id_rn         = rn;
        hz.id_rm         = rm;
        hz.id_uses_rn    = urn;
        hz.id_uses_rm    = urm;
        hz.ex_memread    = memread;
        hz.ex_rd         = rd;
        hz.ex_multicycle = mc;
        hz.br_taken      = br;
        hz.imem_ready    = rdy;
        e.v = expv; e.rst = rst; e.tag = tag;
        exp_q.push_back(e);
        @(negedge clk);
        e = exp_q.pop_front();
        obs = {hz.pc_we, hz.ifid_we, hz.ifid_flush, hz.idex_we, hz.idex_bubble, hz.exmem_bubble};
        checks++;
        assert (obs === e.v) else begin
            errors++;
            $error("FAIL %s ctrl observed=%b expected=%b", e.tag, obs, e.v);
        end
`ifdef HAZARD_PERF_CNT_EN
        exp_stall = stall_model;
        exp_flush = flush_model;
`else
        exp_stall = 32'd0;
        exp_flush = 32'd0;
`endif
        checks++;
        assert (hz.stall_cycles === exp_stall) else begin
            errors++;
            $error("FAIL %s stall_cycles observed=%0d expected=%0d", e.tag, hz.stall_cycles, exp_stall);
        end
        checks++;
        assert (hz.flush_cycles === exp_flush) else begin
            errors++;
            $error("FAIL %s flush_cycles observed=%0d expected=%0d", e.tag, hz.flush_cycles, exp_flush);
        end
        $display("step %-12s ctrl=%b stall=%0d flush=%0d", e.tag, obs, hz.stall_cycles, hz.flush_cycles);
        if (e.rst) begin
            stall_model = 32'd0;
            flush_model = 32'd0;
        end else begin
            if (!e.v[5]) stall_model = stall_model + 32'd1;
            if (e.v[3])  flush_model = flush_model + 32'd1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        hz.id_rn = 5'd0; hz.id_rm = 5'd0; hz.id_uses_rn = 1'b0; hz.id_uses_rm = 1'b0;
        hz.ex_memread = 1'b0; hz.ex_rd = 5'd0; hz.ex_multicycle = 1'b0;
        hz.br_taken = 1'b0; hz.imem_ready = 1'b1;
        @(posedge clk);
        #1;
        //   rst  rn     rm     urn   urm   mrd   rd     mc    br    rdy
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, V_RST, "reset");
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, V_DEF, "idle");
        step(1'b0, 5'd5, 5'd1, 1'b1, 1'b0, 1'b1, 5'd5,  1'b0, 1'b0, 1'b1, V_LU,  "lu_rn");
        step(1'b0, 5'd5, 5'd1, 1'b1, 1'b0, 1'b0, 5'd5,  1'b0, 1'b0, 1'b1, V_DEF, "lu_after");
        step(1'b0, 5'd2, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7,  1'b0, 1'b0, 1'b1, V_LU,  "lu_rm");
        step(1'b0, 5'd31, 5'd1, 1'b1, 1'b0, 1'b1, 5'd31, 1'b0, 1'b0, 1'b1, V_DEF, "lu_xzr");
        step(1'b0, 5'd9, 5'd1, 1'b0, 1'b1, 1'b1, 5'd9,  1'b0, 1'b0, 1'b1, V_DEF, "lu_unused");
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b1, V_BR,  "branch");
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, V_DEF, "br_after");
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, V_BR,  "br_nordy");
        step(1'b0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3,  1'b1, 1'b1, 1'b1, V_BR,  "br_over_all");
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b1, V_MC,  "mc1_c0");
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b1, 1'b1, V_MC,  "mc1_c1_br");
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, V_MC,  "mc1_c2");
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b1, V_DEF, "mc1_release");
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b1, V_MC,  "mc2_c0");
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b1, V_MC,  "mc2_c1");
        step(1'b0, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4,  1'b1, 1'b0, 1'b1, V_MC,  "mc2_c2_lu");
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, V_DEF, "mc2_release");
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, V_FW,  "fetch_w0");
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, V_FW,  "fetch_w1");
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, V_FW,  "fetch_w2");
        step(1'b0, 5'd6, 5'd0, 1'b1, 1'b0, 1'b1, 5'd6,  1'b0, 1'b0, 1'b0, V_LU,  "lu_nordy");
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b1, V_MC,  "mc3_c0");
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b1, V_MC,  "mc3_c1");
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b1, V_RST, "mc3_reset");
        step(1'b0, 5'd8, 5'd8, 1'b0, 1'b1, 1'b1, 5'd8,  1'b0, 1'b0, 1'b1, V_LU,  "post_rst_lu");
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, V_DEF, "final");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
